bridge_dataslot_table: RTL and testbench
========================================

Name: bridge_dataslot_table

Overview:
- Parametrised dataslot parameter table.
- The host writes and reads it over the bridge bus. The core reads it through a second, independent port.
- The block tracks which slots the host has modified and announces them to the core one at a time over a valid/ready update channel.
- It sits between the bridge decode and core logic that reacts to slot updates such as size or parameter changes.

Parameters:
- NUM_SLOTS, 32, number of dataslots; 1..256, need not be a power of two.
- WORDS_PER_SLOT, 2, 32-bit words per slot; power of two, 1..8.
- WORD_IDX_W, $clog2(NUM_SLOTS*WORDS_PER_SLOT), derived flat word-index width; not overridden.

Ports:
- clk  in  1  bridge clock; the single clock of the block.
- reset  in  1  asynchronous, active-high reset.
- bridge_addr  in  32  byte address, already decoded to this block's window; bits [1:0] ignored.
- bridge_wr  in  1  write strobe, one cycle per word.
- bridge_wr_data  in  32  write data.
- bridge_rd_data  out  32  registered read data for bridge_addr.
- core_rd_req  in  1  core read request.
- core_rd_slot  in  8  slot index for the core read.
- core_rd_word  in  3  word within the slot for the core read.
- core_rd_valid  out  1  core read data valid.
- core_rd_data  out  32  core read data.
- upd_valid  out  1  an update notification is pending.
- upd_slot  out  8  index of the updated slot.
- upd_ready  in  1  core accepts the notification.
- dirty  out  NUM_SLOTS  live sticky dirty bitmap, for debug.

Behaviour:
- Addressing
  - Flat word index = bridge_addr[2 +: WORD_IDX_W].
  - slot = index / WORDS_PER_SLOT; word = index % WORDS_PER_SLOT.
  - Index >= NUM_SLOTS*WORDS_PER_SLOT is out of range: writes dropped, reads return 0, no dirty set.
  - Core port index = core_rd_slot*WORDS_PER_SLOT + core_rd_word[log2(WORDS_PER_SLOT)-1:0]. Upper core_rd_word bits are ignored. The same out-of-range rule applies, returning 0.
- Storage
  - Inferred RAM of NUM_SLOTS*WORDS_PER_SLOT x 32.
  - Contents are not reset; the power-up value is undefined.
- Bridge read
  - bridge_rd_data updates every cycle from bridge_addr; latency 1.
  - Read-before-write: a write and a read to the same index in the same cycle returns the old data.
- Core read
  - core_rd_valid = core_rd_req delayed by 1 cycle.
  - core_rd_data is registered and held between requests.
  - Read-before-write against a same-cycle bridge write.
  - Back-to-back requests are allowed at one per cycle.
- Dirty tracking
  - An in-range bridge_wr to any word of slot s sets dirty[s] at the next edge.
  - dirty[s] is cleared only on an accepted notification for s.
  - If a set and a clear of the same bit coincide, the set wins: the bit stays 1 and the slot is re-announced on a later scan.
- Notifier FSM, two states, round-robin pointer ptr (0..NUM_SLOTS-1)
  - SCAN: each cycle tests dirty[ptr].
    - If set: latch upd_slot <= ptr and go to PRESENT.
    - Else: ptr <= ptr+1, wrapping NUM_SLOTS-1 -> 0.
    - A slot that becomes dirty is therefore announced within NUM_SLOTS+1 cycles.
  - PRESENT: upd_valid = 1; upd_slot is stable until accepted.
    - On upd_valid & upd_ready: clear dirty[upd_slot] (subject to the set-wins rule), ptr <= upd_slot+1 with wrap, go to SCAN.
    - upd_valid drops in the following cycle; the minimum gap between notifications is 1 cycle.
  - upd_valid never deasserts without a handshake, except on reset.
- Reset (asynchronous assert)
  - dirty = 0, state = SCAN, ptr = 0.
  - upd_valid = 0, upd_slot = 0.
  - core_rd_valid = 0, core_rd_data = 0, bridge_rd_data = 0.
  - Reset mid-PRESENT drops the notification; pending dirty state is lost. RAM is untouched.

Test Plan:
- Write 0xDEADBEEF to addr 0x08 (slot 1, word 0), then read addr 0x08 -> bridge_rd_data = 0xDEADBEEF one cycle after the address is presented. Same-cycle write of 0x1 plus read of 0x08 returns the old value.
- Write slot 5 word 1 (addr 0x2C) = 0x1234 with upd_ready = 1 -> upd_valid pulses with upd_slot = 5 within 33 cycles. dirty[5] is 1 before the handshake and 0 after.
- Write slots 3, 7 and 30 with upd_ready = 0 -> upd_slot = 3 held stable. Then hold upd_ready = 1 -> notifications in order 3, 7, 30, then none.
- While upd_slot = 4 is presented, write slot 4 in the same cycle as the handshake -> dirty[4] remains 1, and slot 4 is announced again after ptr wraps.
- NUM_SLOTS = 20: write addr 0xA0 (index 40) -> no RAM change, no dirty bit. Read addr 0xA0 -> 0. Core read of slot 25 -> core_rd_valid = 1 with data 0.
- Assert reset during PRESENT for slot 2 -> upd_valid = 0 immediately (asynchronously), dirty = 0. Previously written RAM data is still readable after reset.

Source files
------------

// File: rtl/bridge_dataslot_table_if.sv
// rtl/bridge_dataslot_table_if.sv - bridge, core-read and update-channel signals of the dataslot table
interface bridge_dataslot_table_if #(
    parameter int NUM_SLOTS = 32
);
    logic [31:0]          bridge_addr;
    logic                 bridge_wr;
    logic [31:0]          bridge_wr_data;
    logic [31:0]          bridge_rd_data;
    logic                 core_rd_req;
    logic [7:0]           core_rd_slot;
    logic [2:0]           core_rd_word;
    logic                 core_rd_valid;
    logic [31:0]          core_rd_data;
    logic                 upd_valid;
    logic [7:0]           upd_slot;
    logic                 upd_ready;
    logic [NUM_SLOTS-1:0] dirty;

    modport master (
        output bridge_addr, bridge_wr, bridge_wr_data,
        output core_rd_req, core_rd_slot, core_rd_word,
        output upd_ready,
        input  bridge_rd_data, core_rd_valid, core_rd_data,
        input  upd_valid, upd_slot, dirty
    );

    modport slave (
        input  bridge_addr, bridge_wr, bridge_wr_data,
        input  core_rd_req, core_rd_slot, core_rd_word,
        input  upd_ready,
        output bridge_rd_data, core_rd_valid, core_rd_data,
        output upd_valid, upd_slot, dirty
    );
endinterface

// File: rtl/bridge_dataslot_table.sv
// rtl/bridge_dataslot_table.sv - dataslot parameter table with host/core ports and dirty-slot notifier
module bridge_dataslot_table #(
    parameter int NUM_SLOTS      = 32,
    parameter int WORDS_PER_SLOT = 2,
    parameter int WORD_IDX_W     = $clog2(NUM_SLOTS * WORDS_PER_SLOT)
) (
    input  logic                  clk,
    input  logic                  reset,
    bridge_dataslot_table_if.slave bus
);
    localparam int DEPTH  = NUM_SLOTS * WORDS_PER_SLOT;
    localparam int IDX_W  = (WORD_IDX_W < 1) ? 1 : WORD_IDX_W;
    localparam int PTR_W  = (NUM_SLOTS < 2) ? 1 : $clog2(NUM_SLOTS);
    localparam int CIDX_W = 12;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

    localparam logic [0:0] S_SCAN    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0]     br_idx;
    logic                 br_in_range;
    logic [PTR_W-1:0]     br_slot;
    logic [CIDX_W-1:0]    core_idx;
    logic                 core_in_range;
    logic [IDX_W-1:0]     core_ram_idx;
    logic                 upd_fire;
    logic                 unused_addr;

    logic [31:0]          bridge_rd_data_q, bridge_rd_data_d;
    logic                 core_rd_valid_q, core_rd_valid_d;
    logic [31:0]          core_rd_data_q, core_rd_data_d;
    logic [NUM_SLOTS-1:0] dirty_q, dirty_d;
    logic [0:0]           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     upd_slot_q, upd_slot_d;

    // The address is pre-decoded to this window, so only the word-index bits matter.
    assign unused_addr   = ^bus.bridge_addr;
    assign br_idx        = (WORD_IDX_W == 0) ? '0 : bus.bridge_addr[2 +: IDX_W];
    assign br_in_range   = 32'(br_idx) < 32'(DEPTH);
    assign br_slot       = PTR_W'(32'(br_idx) / 32'(WORDS_PER_SLOT));

    assign core_idx      = CIDX_W'(bus.core_rd_slot) * CIDX_W'(WORDS_PER_SLOT)
                         + CIDX_W'(bus.core_rd_word & 3'(WORDS_PER_SLOT - 1));
    assign core_in_range = 32'(core_idx) < 32'(DEPTH);
    assign core_ram_idx  = core_idx[IDX_W-1:0];

    assign upd_fire      = (state_q == S_PRESENT) && bus.upd_ready;

    always_comb begin
        bridge_rd_data_d = br_in_range ? mem[br_idx] : 32'h0;

        core_rd_valid_d  = bus.core_rd_req;
        core_rd_data_d   = core_rd_data_q;
        if (bus.core_rd_req) begin
            core_rd_data_d = core_in_range ? mem[core_ram_idx] : 32'h0;
        end

        // Clear first, then set, so a host write racing the handshake keeps the slot dirty.
        dirty_d = dirty_q;
        if (upd_fire) begin
            dirty_d[upd_slot_q] = 1'b0;
        end
        if (bus.bridge_wr && br_in_range) begin
            dirty_d[br_slot] = 1'b1;
        end

        state_d    = state_q;
        ptr_d      = ptr_q;
        upd_slot_d = upd_slot_q;
        case (state_q)
            S_SCAN: begin
                if (dirty_q[ptr_q]) begin
                    upd_slot_d = ptr_q;
                    state_d    = S_PRESENT;
                end else begin
                    ptr_d = (ptr_q == LAST_SLOT) ? '0 : ptr_q + 1'b1;
                end
            end
            default: begin
                if (upd_fire) begin
                    ptr_d   = (upd_slot_q == LAST_SLOT) ? '0 : upd_slot_q + 1'b1;
                    state_d = S_SCAN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bridge_rd_data_q <= 32'h0;
            core_rd_valid_q  <= 1'b0;
            core_rd_data_q   <= 32'h0;
            dirty_q          <= '0;
            state_q          <= S_SCAN;
            ptr_q            <= '0;
            upd_slot_q       <= '0;
        end else begin
            bridge_rd_data_q <= bridge_rd_data_d;
            core_rd_valid_q  <= core_rd_valid_d;
            core_rd_data_q   <= core_rd_data_d;
            dirty_q          <= dirty_d;
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            upd_slot_q       <= upd_slot_d;
        end
    end

    // Table contents survive reset; only the bridge port writes them.
    always_ff @(posedge clk) begin
        if (bus.bridge_wr && br_in_range) begin
            mem[br_idx] <= bus.bridge_wr_data;
        end
    end

    assign bus.bridge_rd_data = bridge_rd_data_q;
    assign bus.core_rd_valid  = core_rd_valid_q;
    assign bus.core_rd_data   = core_rd_data_q;
    assign bus.upd_valid      = (state_q == S_PRESENT);
    assign bus.upd_slot       = 8'(upd_slot_q);
    assign bus.dirty          = dirty_q;
endmodule

// File: tb/tb_bridge_dataslot_table.sv
// tb/tb_bridge_dataslot_table.sv - scoreboard bench for bridge_dataslot_table
module tb_bridge_dataslot_table;
    localparam int NS    = 32;
    localparam int WPS   = 2;
    localparam int DEPTH = NS * WPS;
    localparam int NS2   = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bridge_dataslot_table_if #(.NUM_SLOTS(NS))  bus  ();
    bridge_dataslot_table_if #(.NUM_SLOTS(NS2)) bus2 ();

    bridge_dataslot_table #(.NUM_SLOTS(NS), .WORDS_PER_SLOT(WPS)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    bridge_dataslot_table #(.NUM_SLOTS(NS2), .WORDS_PER_SLOT(WPS)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    typedef struct {
        int          due;
        bit          is_core;
        bit          known;
        bit          valid;
        logic [31:0] data;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs_count = 0;

    logic [31:0] mem_m [DEPTH];
    bit          known_m [DEPTH];
    bit [NS-1:0] dirty_m;
    logic [31:0] core_last;
    bit          core_last_known;
    exp_t        expq[$];
    int          exp_upd[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Drive one cycle of stimulus and record what the table must return one cycle later.
    task automatic step(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input bit creq, input logic [7:0] cs, input logic [2:0] cw, input bit rdy);
        int   idx;
        int   cidx;
        exp_t e;
        @(posedge clk);
        #1;
        bus.bridge_wr      = wr;
        bus.bridge_addr    = addr;
        bus.bridge_wr_data = wd;
        bus.core_rd_req    = creq;
        bus.core_rd_slot   = cs;
        bus.core_rd_word   = cw;
        bus.upd_ready      = rdy;
        idx = int'((addr >> 2) % 32'(DEPTH));
        e.due = cyc + 1; e.is_core = 1'b0; e.valid = 1'b0;
        e.known = known_m[idx]; e.data = mem_m[idx];
        expq.push_back(e);
        if (creq) begin
            if (int'(cs) >= NS) begin
                core_last = 32'h0; core_last_known = 1'b1;
            end else begin
                cidx = int'(cs) * WPS + int'(cw) % WPS;
                core_last = mem_m[cidx]; core_last_known = known_m[cidx];
            end
        end
        e.is_core = 1'b1; e.valid = creq; e.known = core_last_known; e.data = core_last;
        expq.push_back(e);
        if (wr) begin
            mem_m[idx]   = wd;
            known_m[idx] = 1'b1;
        end
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, bus.bridge_addr, 32'h0, 1'b0, 8'h0, 3'h0, rdy);
    endtask

    task automatic wait_valid(input bit rdy, input int budget, output int n);
        n = -1;
        for (int i = 0; i < budget; i++) begin
            idle(rdy);
            if (bus.upd_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulse_reset_async();
        @(posedge clk);
        #3;
        bus.bridge_wr   = 1'b0;
        bus.core_rd_req = 1'b0;
        bus.upd_ready   = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_upd_valid", 32'(bus.upd_valid), 32'h0);
        chk("rst_dirty", bus.dirty, 32'h0);
        chk("rst_bridge_rd_data", bus.bridge_rd_data, 32'h0);
        chk("rst_core_rd_valid", 32'(bus.core_rd_valid), 32'h0);
        chk("rst_core_rd_data", bus.core_rd_data, 32'h0);
        expq.delete();
        exp_upd.delete();
        core_last = 32'h0; core_last_known = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: scoreboard pops, dirty-set model and update-channel rules.
    initial begin
        exp_t        e;
        bit [NS-1:0] nxt;
        bit          prev_hold = 1'b0;
        logic [7:0]  prev_slot = 8'h0;
        int          widx;
        forever begin
            @(negedge clk);
            if (reset) begin
                dirty_m   = '0;
                prev_hold = 1'b0;
            end else begin
                chk("dirty_vector", bus.dirty, dirty_m);
                while (expq.size() > 0 && expq[0].due <= cyc) begin
                    e = expq.pop_front();
                    if (e.is_core) begin
                        chk("core_rd_valid", 32'(bus.core_rd_valid), 32'(e.valid));
                        if (e.known) chk("core_rd_data", bus.core_rd_data, e.data);
                    end else if (e.known) begin
                        chk("bridge_rd_data", bus.bridge_rd_data, e.data);
                    end
                end
                if (prev_hold) begin
                    chk("upd_valid_held", 32'(bus.upd_valid), 32'h1);
                    chk("upd_slot_stable", 32'(bus.upd_slot), 32'(prev_slot));
                end
                if (bus.upd_valid) chk("upd_slot_is_dirty", 32'(dirty_m[bus.upd_slot]), 32'h1);
                nxt = dirty_m;
                if (bus.upd_valid && bus.upd_ready) begin
                    hs_count++;
                    if (exp_upd.size() > 0) chk("upd_order", 32'(bus.upd_slot), 32'(exp_upd.pop_front()));
                    nxt[bus.upd_slot] = 1'b0;
                end
                if (bus.bridge_wr) begin
                    widx = int'((bus.bridge_addr >> 2) % 32'(DEPTH));
                    nxt[widx / WPS] = 1'b1;
                end
                dirty_m   = nxt;
                prev_hold = bus.upd_valid && !bus.upd_ready;
                prev_slot = bus.upd_slot;
            end
        end
    end

    task automatic d2_cycle(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            input bit creq, input logic [7:0] cs, input logic [2:0] cw);
        @(posedge clk);
        #1;
        bus2.bridge_wr = wr; bus2.bridge_addr = addr; bus2.bridge_wr_data = wd;
        bus2.core_rd_req = creq; bus2.core_rd_slot = cs; bus2.core_rd_word = cw;
        @(posedge clk);
        #1;
        bus2.bridge_wr = 1'b0; bus2.core_rd_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          hs0;
        logic [31:0] v;
        reset = 1'b1;
        bus.bridge_addr = 32'h0; bus.bridge_wr = 1'b0; bus.bridge_wr_data = 32'h0;
        bus.core_rd_req = 1'b0; bus.core_rd_slot = 8'h0; bus.core_rd_word = 3'h0; bus.upd_ready = 1'b0;
        bus2.bridge_addr = 32'h0; bus2.bridge_wr = 1'b0; bus2.bridge_wr_data = 32'h0;
        bus2.core_rd_req = 1'b0; bus2.core_rd_slot = 8'h0; bus2.core_rd_word = 3'h0; bus2.upd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            known_m[i] = 1'b0;
            mem_m[i]   = 32'h0;
        end
        dirty_m = '0;
        core_last = 32'h0; core_last_known = 1'b1;
        #12;
        chk("init_upd_valid", 32'(bus.upd_valid), 32'h0);
        chk("init_upd_slot", 32'(bus.upd_slot), 32'h0);
        chk("init_dirty", bus.dirty, 32'h0);
        chk("init_bridge_rd_data", bus.bridge_rd_data, 32'h0);
        chk("init_core_rd_valid", 32'(bus.core_rd_valid), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic write/read and read-before-write on both ports.
        step(1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 8'h0, 3'h0, 1'b1);
        step(1'b0, 32'h08, 32'h0, 1'b0, 8'h0, 3'h0, 1'b1);
        step(1'b1, 32'h08, 32'h1, 1'b1, 8'd1, 3'd0, 1'b1);
        step(1'b0, 32'h08, 32'h0, 1'b1, 8'd1, 3'd6, 1'b1);
        for (int i = 0; i < 40; i++) idle(1'b1);

        // Single notification latency and dirty bit life cycle.
        exp_upd.push_back(5);
        step(1'b1, 32'h2C, 32'h1234, 1'b0, 8'h0, 3'h0, 1'b1);
        wait_valid(1'b1, 40, n);
        chk("t2_latency_ok", 32'(n >= 0 && n <= 33), 32'h1);
        chk("t2_upd_slot", 32'(bus.upd_slot), 32'd5);
        chk("t2_dirty5_before", 32'(bus.dirty[5]), 32'h1);
        idle(1'b1);
        chk("t2_valid_dropped", 32'(bus.upd_valid), 32'h0);
        chk("t2_dirty5_after", 32'(bus.dirty[5]), 32'h0);

        // Ordered drain of three dirty slots after backpressure.
        pulse_reset_async();
        exp_upd.push_back(3); exp_upd.push_back(7); exp_upd.push_back(30);
        step(1'b1, 32'h18, $urandom(), 1'b0, 8'h0, 3'h0, 1'b0);
        step(1'b1, 32'h38, $urandom(), 1'b0, 8'h0, 3'h0, 1'b0);
        step(1'b1, 32'hF4, $urandom(), 1'b0, 8'h0, 3'h0, 1'b0);
        wait_valid(1'b0, 40, n);
        chk("t3_first_found", 32'(n >= 0), 32'h1);
        chk("t3_first_slot", 32'(bus.upd_slot), 32'd3);
        for (int i = 0; i < 5; i++) idle(1'b0);
        hs0 = hs_count;
        for (int i = 0; i < 100; i++) idle(1'b1);
        chk("t3_handshakes", 32'(hs_count - hs0), 32'd3);
        chk("t3_order_consumed", 32'(exp_upd.size()), 32'h0);

        // Host write coinciding with the handshake keeps the slot dirty.
        pulse_reset_async();
        exp_upd.push_back(4); exp_upd.push_back(4);
        step(1'b1, 32'h20, $urandom(), 1'b0, 8'h0, 3'h0, 1'b0);
        wait_valid(1'b0, 40, n);
        chk("t4_slot", 32'(bus.upd_slot), 32'd4);
        step(1'b1, 32'h24, $urandom(), 1'b0, 8'h0, 3'h0, 1'b1);
        idle(1'b0);
        chk("t4_dirty4_kept", 32'(bus.dirty[4]), 32'h1);
        chk("t4_valid_dropped", 32'(bus.upd_valid), 32'h0);
        wait_valid(1'b0, 40, n);
        chk("t4_reannounce_found", 32'(n >= 0), 32'h1);
        chk("t4_reannounce_slot", 32'(bus.upd_slot), 32'd4);
        idle(1'b1);
        idle(1'b0);
        chk("t4_dirty_clear", bus.dirty, 32'h0);

        // Reset while presenting drops the notification but keeps RAM.
        pulse_reset_async();
        v = $urandom();
        step(1'b1, 32'h10, v, 1'b0, 8'h0, 3'h0, 1'b0);
        wait_valid(1'b0, 40, n);
        chk("t6_slot", 32'(bus.upd_slot), 32'd2);
        pulse_reset_async();
        step(1'b0, 32'h10, 32'h0, 1'b1, 8'd2, 3'd0, 1'b0);
        idle(1'b0);
        chk("t6_ram_kept_bridge", bus.bridge_rd_data, v);
        chk("t6_ram_kept_core", bus.core_rd_data, v);

        // Random traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            step(($urandom() % 3) == 0, $urandom(), $urandom(), $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 39)), 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 120; i++) idle(1'b1);
        chk("drain_dirty", bus.dirty, 32'h0);
        chk("drain_upd_valid", 32'(bus.upd_valid), 32'h0);

        // Twenty-slot table: out-of-range index handling.
        d2_cycle(1'b1, 32'h9C, 32'hCAFE0039, 1'b0, 8'h0, 3'h0);
        d2_cycle(1'b1, 32'hA0, 32'h55555555, 1'b0, 8'h0, 3'h0);
        chk("n20_dirty_only_19", 32'(bus2.dirty), 32'h00080000);
        d2_cycle(1'b0, 32'h9C, 32'h0, 1'b1, 8'd19, 3'd1);
        chk("n20_bridge_rd_39", bus2.bridge_rd_data, 32'hCAFE0039);
        chk("n20_core_rd_39_valid", 32'(bus2.core_rd_valid), 32'h1);
        chk("n20_core_rd_39_data", bus2.core_rd_data, 32'hCAFE0039);
        d2_cycle(1'b0, 32'hA0, 32'h0, 1'b1, 8'd25, 3'd0);
        chk("n20_bridge_rd_oor", bus2.bridge_rd_data, 32'h0);
        chk("n20_core_oor_valid", 32'(bus2.core_rd_valid), 32'h1);
        chk("n20_core_oor_data", bus2.core_rd_data, 32'h0);
        d2_cycle(1'b0, 32'h9C, 32'h0, 1'b0, 8'h0, 3'h0);
        chk("n20_core_valid_drop", 32'(bus2.core_rd_valid), 32'h0);
        chk("n20_core_data_held", bus2.core_rd_data, 32'h0);
        chk("n20_bridge_rd_39_again", bus2.bridge_rd_data, 32'hCAFE0039);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
